// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, the exception/interrupt return
// address (epc), the kernel-mode flag and the IF/ID pipeline register.
// Next-PC selection is a strict priority chain: exception, interrupt,
// eret, branch, jump, stall, sequential.
module instruction_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h00000000,
  parameter logic [31:0] IRQ_VEC   = 32'h00000004,
  parameter logic [31:0] EXC_VEC   = 32'h00000008,
  parameter logic [31:0] NOP       = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        branch_take,
  input  logic [31:0] branch_target,
  input  logic        jump_take,
  input  logic [31:0] jump_target,
  input  logic        eret_take,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        irq_req,
  output logic        irq_ack,
  output logic [31:0] epc,
  output logic        kernel,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  // Everything loaded into the PC on a redirect is word aligned.
  localparam logic [31:0] ALIGN_MASK = 32'hFFFFFFFC;
  localparam logic [31:0] IRQ_VEC_AL = IRQ_VEC & ALIGN_MASK;
  localparam logic [31:0] EXC_VEC_AL = EXC_VEC & ALIGN_MASK;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_IRQ,
    SEL_ERET,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_STALL,
    SEL_SEQ
  } pcSel_e;

  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_kernel;
  logic [31:0] r_ifIdInstr;
  logic [31:0] r_ifIdPc4;
  logic        r_ifIdValid;

  logic        w_irqTake;
  pcSel_e      w_sel;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_branchAl;
  logic [31:0] w_jumpAl;
  logic [31:0] w_epcAl;
  logic [31:0] w_irqResume;
  logic [31:0] w_nextPc;
  logic [31:0] w_nextEpc;
  logic        w_nextKernel;
  logic        w_redirect;

  // Aligned redirect targets and the sequential successor (wraps at 2^32).
  always_comb begin
    w_pcPlus4  = r_pc + 32'd4;
    w_branchAl = branch_target & ALIGN_MASK;
    w_jumpAl   = jump_target & ALIGN_MASK;
    w_epcAl    = r_epc & ALIGN_MASK;
  end

  // An interrupt is only accepted in user mode and never against an exception,
  // so a blocked irq simply stays pending on the level-sensitive request.
  always_comb begin
    w_irqTake = irq_req && !r_kernel && !exc_req;
  end

  // Resume address for an interrupt: the fetch that the interrupt displaces.
  always_comb begin
    if (branch_take) begin
      w_irqResume = w_branchAl;
    end else if (jump_take) begin
      w_irqResume = w_jumpAl;
    end else begin
      w_irqResume = r_pc;
    end
  end

  // Strict-priority choice of where the PC goes next.
  always_comb begin
    if (exc_req) begin
      w_sel = SEL_EXC;
    end else if (w_irqTake) begin
      w_sel = SEL_IRQ;
    end else if (eret_take) begin
      w_sel = SEL_ERET;
    end else if (branch_take) begin
      w_sel = SEL_BRANCH;
    end else if (jump_take) begin
      w_sel = SEL_JUMP;
    end else if (stall) begin
      w_sel = SEL_STALL;
    end else begin
      w_sel = SEL_SEQ;
    end
  end

  // Next-state values for PC, epc and kernel for the selected event.
  always_comb begin
    w_nextPc     = r_pc;
    w_nextEpc    = r_epc;
    w_nextKernel = r_kernel;
    w_redirect   = 1'b0;
    case (w_sel)
      SEL_EXC: begin
        w_nextPc     = EXC_VEC_AL;
        w_nextEpc    = exc_pc;
        w_nextKernel = 1'b1;
        w_redirect   = 1'b1;
      end
      SEL_IRQ: begin
        w_nextPc     = IRQ_VEC_AL;
        w_nextEpc    = w_irqResume;
        w_nextKernel = 1'b1;
        w_redirect   = 1'b1;
      end
      SEL_ERET: begin
        w_nextPc     = w_epcAl;
        w_nextKernel = 1'b0;
        w_redirect   = 1'b1;
      end
      SEL_BRANCH: begin
        w_nextPc   = w_branchAl;
        w_redirect = 1'b1;
      end
      SEL_JUMP: begin
        w_nextPc   = w_jumpAl;
        w_redirect = 1'b1;
      end
      SEL_STALL: begin
        w_nextPc = r_pc;
      end
      SEL_SEQ: begin
        w_nextPc = w_pcPlus4;
      end
      default: begin
        w_nextPc = r_pc;
      end
    endcase
  end

  // PC, epc and kernel flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_VEC;
      r_epc    <= 32'h00000000;
      r_kernel <= 1'b0;
    end else begin
      r_pc     <= w_nextPc;
      r_epc    <= w_nextEpc;
      r_kernel <= w_nextKernel;
    end
  end

  // IF/ID register: bubbles on any redirect, holds on stall, captures otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifIdInstr <= NOP;
      r_ifIdPc4   <= 32'h00000000;
      r_ifIdValid <= 1'b0;
    end else if (w_redirect) begin
      r_ifIdInstr <= NOP;
      r_ifIdValid <= 1'b0;
    end else if (w_sel == SEL_SEQ) begin
      r_ifIdInstr <= Instruction;
      r_ifIdPc4   <= w_pcPlus4;
      r_ifIdValid <= 1'b1;
    end
  end

  // Output drive; the ack is masked during reset so it is forced low then.
  always_comb begin
    Address     = r_pc;
    epc         = r_epc;
    kernel      = r_kernel;
    if_id_instr = r_ifIdInstr;
    if_id_pc4   = r_ifIdPc4;
    if_id_valid = r_ifIdValid;
    irq_ack     = w_irqTake && !reset;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a combinational memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        stall;
  logic        branch_take;
  logic [31:0] branch_target;
  logic        jump_take;
  logic [31:0] jump_target;
  logic        eret_take;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        irq_req;
  logic        irq_ack;
  logic [31:0] epc;
  logic        kernel;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks   = 0;
  int failures = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Memory image: a jump word at address 0, address-tagged words elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h08000003;
    return a ^ 32'hC0DE0000;
  endfunction

  assign Instruction = memWord(Address);

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .Instruction  (Instruction),
    .stall        (stall),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .jump_take    (jump_take),
    .jump_target  (jump_target),
    .eret_take    (eret_take),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .irq_req      (irq_req),
    .irq_ack      (irq_ack),
    .epc          (epc),
    .kernel       (kernel),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  // Advance one rising edge and settle just after it.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (Address !== 32'h0) begin failures++; $display("[TB] FAIL rst_addr actual=%h required=%h", Address, 32'h0); end
    checks++; if (epc !== 32'h0) begin failures++; $display("[TB] FAIL rst_epc actual=%h required=%h", epc, 32'h0); end
    checks++; if (kernel !== 1'b0) begin failures++; $display("[TB] FAIL rst_kernel actual=%b required=0", kernel); end
    checks++; if (irq_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack actual=%b required=0", irq_ack); end
    checks++; if (if_id_instr !== 32'h0) begin failures++; $display("[TB] FAIL rst_instr actual=%h required=%h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin failures++; $display("[TB] FAIL rst_pc4 actual=%h required=%h", if_id_pc4, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid actual=%b required=0", if_id_valid); end
    stepClk();
    checks++; if (Address !== 32'h0) begin failures++; $display("[TB] FAIL rst_hold_addr actual=%h required=%h", Address, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    checks++; if (Address !== 32'h0) begin failures++; $display("[TB] FAIL seq_c0 actual=%h required=%h", Address, 32'h0); end
    stepClk();
    checks++; if (Address !== 32'h4) begin failures++; $display("[TB] FAIL seq_c1 actual=%h required=%h", Address, 32'h4); end
    checks++; if (if_id_instr !== 32'h08000003) begin failures++; $display("[TB] FAIL seq_instr1 actual=%h required=%h", if_id_instr, 32'h08000003); end
    checks++; if (if_id_pc4 !== 32'h4) begin failures++; $display("[TB] FAIL seq_pc4_1 actual=%h required=%h", if_id_pc4, 32'h4); end
    checks++; if (if_id_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid1 actual=%b required=1", if_id_valid); end
    stepClk();
    checks++; if (Address !== 32'h8) begin failures++; $display("[TB] FAIL seq_c2 actual=%h required=%h", Address, 32'h8); end
    checks++; if (if_id_instr !== 32'hC0DE0004) begin failures++; $display("[TB] FAIL seq_instr2 actual=%h required=%h", if_id_instr, 32'hC0DE0004); end
    stepClk();
    checks++; if (Address !== 32'hC) begin failures++; $display("[TB] FAIL seq_c3 actual=%h required=%h", Address, 32'hC); end
    stepClk();
    checks++; if (Address !== 32'h10) begin failures++; $display("[TB] FAIL seq_c4 actual=%h required=%h", Address, 32'h10); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    stepClk();
    stepClk();
    checks++; if (Address !== 32'h10) begin failures++; $display("[TB] FAIL stall_addr actual=%h required=%h", Address, 32'h10); end
    checks++; if (if_id_instr !== 32'hC0DE000C) begin failures++; $display("[TB] FAIL stall_instr actual=%h required=%h", if_id_instr, 32'hC0DE000C); end
    checks++; if (if_id_pc4 !== 32'h10) begin failures++; $display("[TB] FAIL stall_pc4 actual=%h required=%h", if_id_pc4, 32'h10); end
    checks++; if (if_id_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid actual=%b required=1", if_id_valid); end
    stall = 1'b0;
    stepClk();
    checks++; if (Address !== 32'h14) begin failures++; $display("[TB] FAIL stall_rel_addr actual=%h required=%h", Address, 32'h14); end
    checks++; if (if_id_instr !== 32'hC0DE0010) begin failures++; $display("[TB] FAIL stall_rel_instr actual=%h required=%h", if_id_instr, 32'hC0DE0010); end
    checks++; if (if_id_pc4 !== 32'h14) begin failures++; $display("[TB] FAIL stall_rel_pc4 actual=%h required=%h", if_id_pc4, 32'h14); end
  endtask

  task automatic test_branch_over_jump();
    branch_take = 1'b1; branch_target = 32'h40;
    jump_take   = 1'b1; jump_target   = 32'h80;
    stepClk();
    branch_take = 1'b0; jump_take = 1'b0;
    checks++; if (Address !== 32'h40) begin failures++; $display("[TB] FAIL bj_addr actual=%h required=%h", Address, 32'h40); end
    checks++; if (if_id_instr !== 32'h0) begin failures++; $display("[TB] FAIL bj_nop actual=%h required=%h", if_id_instr, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL bj_valid actual=%b required=0", if_id_valid); end
    checks++; if (if_id_pc4 !== 32'h14) begin failures++; $display("[TB] FAIL bj_pc4_hold actual=%h required=%h", if_id_pc4, 32'h14); end
  endtask

  task automatic test_irq_eret();
    jump_take = 1'b1; jump_target = 32'h20;
    stepClk();
    jump_take = 1'b0;
    checks++; if (Address !== 32'h20) begin failures++; $display("[TB] FAIL irq_pre_addr actual=%h required=%h", Address, 32'h20); end
    irq_req = 1'b1;
    #1;
    checks++; if (irq_ack !== 1'b1) begin failures++; $display("[TB] FAIL irq_ack_take actual=%b required=1", irq_ack); end
    stepClk();
    checks++; if (Address !== 32'h4) begin failures++; $display("[TB] FAIL irq_addr actual=%h required=%h", Address, 32'h4); end
    checks++; if (epc !== 32'h20) begin failures++; $display("[TB] FAIL irq_epc actual=%h required=%h", epc, 32'h20); end
    checks++; if (kernel !== 1'b1) begin failures++; $display("[TB] FAIL irq_kernel actual=%b required=1", kernel); end
    checks++; if (irq_ack !== 1'b0) begin failures++; $display("[TB] FAIL irq_ack_pulse actual=%b required=0", irq_ack); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL irq_valid actual=%b required=0", if_id_valid); end
    stepClk();
    checks++; if (Address !== 32'h8) begin failures++; $display("[TB] FAIL irq_handler_addr actual=%h required=%h", Address, 32'h8); end
    checks++; if (irq_ack !== 1'b0) begin failures++; $display("[TB] FAIL irq_nested_ack actual=%b required=0", irq_ack); end
    eret_take = 1'b1;
    stepClk();
    eret_take = 1'b0;
    checks++; if (Address !== 32'h20) begin failures++; $display("[TB] FAIL eret_addr actual=%h required=%h", Address, 32'h20); end
    checks++; if (kernel !== 1'b0) begin failures++; $display("[TB] FAIL eret_kernel actual=%b required=0", kernel); end
    #1;
    checks++; if (irq_ack !== 1'b1) begin failures++; $display("[TB] FAIL irq_pending_ack actual=%b required=1", irq_ack); end
    stepClk();
    checks++; if (Address !== 32'h4) begin failures++; $display("[TB] FAIL irq2_addr actual=%h required=%h", Address, 32'h4); end
    checks++; if (epc !== 32'h20) begin failures++; $display("[TB] FAIL irq2_epc actual=%h required=%h", epc, 32'h20); end
    irq_req = 1'b0; eret_take = 1'b1;
    stepClk();
    eret_take = 1'b0;
    // Interrupt displacing a branch resumes at the branch target.
    irq_req = 1'b1; branch_take = 1'b1; branch_target = 32'h50;
    stepClk();
    irq_req = 1'b0; branch_take = 1'b0;
    checks++; if (epc !== 32'h50) begin failures++; $display("[TB] FAIL irq_br_epc actual=%h required=%h", epc, 32'h50); end
    checks++; if (Address !== 32'h4) begin failures++; $display("[TB] FAIL irq_br_addr actual=%h required=%h", Address, 32'h4); end
    eret_take = 1'b1;
    stepClk();
    eret_take = 1'b0;
    checks++; if (Address !== 32'h50) begin failures++; $display("[TB] FAIL eret_br_addr actual=%h required=%h", Address, 32'h50); end
  endtask

  task automatic test_exc_beats_irq();
    exc_req = 1'b1; exc_pc = 32'h18; irq_req = 1'b1;
    #1;
    checks++; if (irq_ack !== 1'b0) begin failures++; $display("[TB] FAIL exc_ack actual=%b required=0", irq_ack); end
    stepClk();
    exc_req = 1'b0;
    checks++; if (Address !== 32'h8) begin failures++; $display("[TB] FAIL exc_addr actual=%h required=%h", Address, 32'h8); end
    checks++; if (epc !== 32'h18) begin failures++; $display("[TB] FAIL exc_epc actual=%h required=%h", epc, 32'h18); end
    checks++; if (kernel !== 1'b1) begin failures++; $display("[TB] FAIL exc_kernel actual=%b required=1", kernel); end
    #1;
    checks++; if (irq_ack !== 1'b0) begin failures++; $display("[TB] FAIL exc_handler_ack actual=%b required=0", irq_ack); end
    eret_take = 1'b1;
    stepClk();
    eret_take = 1'b0;
    checks++; if (Address !== 32'h18) begin failures++; $display("[TB] FAIL exc_eret_addr actual=%h required=%h", Address, 32'h18); end
    #1;
    checks++; if (irq_ack !== 1'b1) begin failures++; $display("[TB] FAIL exc_irq_pending actual=%b required=1", irq_ack); end
    irq_req = 1'b0;
    stepClk();
    checks++; if (Address !== 32'h1C) begin failures++; $display("[TB] FAIL exc_seq_addr actual=%h required=%h", Address, 32'h1C); end
    checks++; if (if_id_instr !== 32'hC0DE0018) begin failures++; $display("[TB] FAIL exc_seq_instr actual=%h required=%h", if_id_instr, 32'hC0DE0018); end
  endtask

  task automatic test_wrap_align();
    jump_take = 1'b1; jump_target = 32'hFFFFFFFC;
    stepClk();
    jump_take = 1'b0;
    checks++; if (Address !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL wrap_pre actual=%h required=%h", Address, 32'hFFFFFFFC); end
    stepClk();
    checks++; if (Address !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr actual=%h required=%h", Address, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc4 actual=%h required=%h", if_id_pc4, 32'h0); end
    checks++; if (if_id_instr !== 32'h3F21FFFC) begin failures++; $display("[TB] FAIL wrap_instr actual=%h required=%h", if_id_instr, 32'h3F21FFFC); end
    jump_take = 1'b1; jump_target = 32'h33;
    stepClk();
    jump_take = 1'b0;
    checks++; if (Address !== 32'h30) begin failures++; $display("[TB] FAIL align_addr actual=%h required=%h", Address, 32'h30); end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1; jump_take = 1'b1; jump_target = 32'h100;
    stepClk();
    jump_take = 1'b0;
    checks++; if (Address !== 32'h100) begin failures++; $display("[TB] FAIL b2b_jump actual=%h required=%h", Address, 32'h100); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid actual=%b required=0", if_id_valid); end
    stepClk();
    stall = 1'b0;
    checks++; if (Address !== 32'h100) begin failures++; $display("[TB] FAIL b2b_stall actual=%h required=%h", Address, 32'h100); end
  endtask

  task automatic test_reset_mid_handler();
    irq_req = 1'b1;
    stepClk();
    irq_req = 1'b0;
    checks++; if (kernel !== 1'b1) begin failures++; $display("[TB] FAIL mid_kernel actual=%b required=1", kernel); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (Address !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_addr actual=%h required=%h", Address, 32'h0); end
    checks++; if (kernel !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_kernel actual=%b required=0", kernel); end
    checks++; if (epc !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_epc actual=%h required=%h", epc, 32'h0); end
    checks++; if (if_id_pc4 !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_pc4 actual=%h required=%h", if_id_pc4, 32'h0); end
    stepClk();
    reset = 1'b0;
    stepClk();
    checks++; if (Address !== 32'h4) begin failures++; $display("[TB] FAIL post_rst_addr actual=%h required=%h", Address, 32'h4); end
    checks++; if (if_id_instr !== 32'h08000003) begin failures++; $display("[TB] FAIL post_rst_instr actual=%h required=%h", if_id_instr, 32'h08000003); end
  endtask

  // Scenario sequence; each scenario starts where the previous one left the PC.
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    branch_take = 1'b0; branch_target = 32'h0;
    jump_take = 1'b0;   jump_target = 32'h0;
    eret_take = 1'b0;
    exc_req = 1'b0;     exc_pc = 32'h0;
    irq_req = 1'b0;
    #3;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_jump();
    test_irq_eret();
    test_exc_beats_irq();
    test_wrap_align();
    test_back_to_back();
    test_reset_mid_handler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
